txuart: RTL and testbench
=========================

Name: txuart

Overview:
- UART transmitter: the counterpart of the existing UART receiver.
- Serialises bytes from game logic (score, status, echo of received key codes) onto the board's TX line to the host computer.
- Contains a small write FIFO, so callers can push a burst of bytes without handshaking on every bit.
- Frame format matches the receiver: 8N1 by default, optional even parity, LSB first.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- baudRate, 115200, line rate in bits/s; CLKS_PER_BIT = CLK_FREQ / baudRate, integer division (217 at defaults).
- if_parity, 1'b0, when 1 an even-parity bit is inserted between D7 and the stop bit.
- FIFO_DEPTH, 4, number of byte entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock, 25 MHz.
- rstn  input  1  reset, asynchronous, active-low.
- i_wr  input  1  write strobe; a byte is pushed on every clk edge where i_wr=1 and the push is accepted.
- i_data  input  8  byte to transmit, sampled with i_wr.
- o_full  output  1  FIFO holds FIFO_DEPTH entries.
- o_empty  output  1  FIFO holds 0 entries.
- o_busy  output  1  FSM not in IDLE, or FIFO not empty.
- o_uart_tx  output  1  serial line, registered, idles high.

Behaviour:
Reset (rstn=0, asynchronous):
- o_uart_tx=1, o_full=0, o_empty=1, o_busy=0.
- FIFO pointers and count cleared, FSM=IDLE, bit and baud counters zeroed.
- Reset mid-frame aborts the frame; the line goes high immediately and queued bytes are discarded.

FIFO:
- Circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits that wrap naturally, plus a count of log2(FIFO_DEPTH)+1 bits.
- Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
- A push while full with no pop is silently dropped: no state change.
- Simultaneous push and pop: count unchanged, both pointers advance.
- o_full and o_empty are decoded from the registered count.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_uart_tx=1.
  - If FIFO not empty: pop the head into shift register sh[7:0], compute par=^head, clear the baud counter, go to START.
- START:
  - o_uart_tx=0 for CLKS_PER_BIT cycles.
  - Then go to DATA with bit_idx=0.
- DATA:
  - o_uart_tx=sh[0] for CLKS_PER_BIT cycles, then shift sh right and bit_idx++.
  - After bit_idx=7 completes: go to PARITY if if_parity, else STOP.
- PARITY:
  - o_uart_tx=par (even parity: total ones over D0..D7+P is even) for CLKS_PER_BIT cycles.
  - Then go to STOP.
- STOP:
  - o_uart_tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle: if FIFO not empty, pop and go directly to START (no idle gap between frames); else go to IDLE.

Baud counter:
- Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Width is clog2(CLKS_PER_BIT).

Timing:
- Latency: i_wr at edge N with FIFO empty and FSM idle → pop at edge N+1 → o_uart_tx falls after edge N+2.
- Frame length: 10*CLKS_PER_BIT clocks (2170 at defaults), or 11*CLKS_PER_BIT with parity.

Write-only sequencing:
- No back-pressure beyond o_full.
- A caller writing one byte per clock fills the FIFO in FIFO_DEPTH cycles; further bytes are dropped until a pop occurs.

Test Plan:
- Reset then single write 0x41, if_parity=0:
  - o_uart_tx low 2 clocks after i_wr.
  - Line samples at bit centres are 0,1,0,0,0,0,0,1,0,1 (start, D0..D7, stop).
  - Each bit lasts 217 clocks; o_busy drops after 2170 clocks.
- if_parity=1, byte 0x41 then 0x07:
  - Parity bit 0 for 0x41 and 1 for 0x07.
  - Frames are 2387 clocks each and back-to-back, with no high gap beyond the stop bit.
- Burst of 6 writes 0x10..0x15 on consecutive clocks, FIFO_DEPTH=4:
  - 0x10 is popped on the second cycle, so 0x10..0x14 are accepted and 0x15 is dropped.
  - o_full asserts.
  - Bytes 0x10..0x14 are transmitted in order.
- Write while full, same cycle as the STOP→START pop:
  - The byte is accepted and count stays at 4.
  - All bytes are transmitted, with none lost or duplicated.
- Assert rstn=0 midway through D3 of a frame with 2 bytes queued:
  - o_uart_tx=1 asynchronously, o_empty=1, o_busy=0.
  - After release the line stays high with no further frames.
- Pointer wrap-around: stream 10 bytes 0x00..0x09, writing only when !o_full → all 10 are received in order by the existing UART receiver in loopback.

Source files
------------

// File: rtl/txuart.sv
// rtl/txuart.sv - UART transmitter with a small write FIFO, 8N1 or 8E1, LSB first
module txuart #(
    parameter int   CLK_FREQ   = 25000000,
    parameter int   baudRate   = 115200,
    parameter logic if_parity  = 1'b0,
    parameter int   FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_busy,
    output logic       o_uart_tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / baudRate;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW:0]     r_count;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_sh;
    logic            r_par;
    logic            r_tx;
    logic            w_pop;
    logic            w_push;
    logic            w_baud_done;
    logic            w_tx_next;

    assign w_baud_done = (r_baud == BAUD_LAST);
    assign o_full      = (r_count == COUNT_FULL);
    assign o_empty     = (r_count == '0);
    assign o_busy      = (r_state != IDLE) || !o_empty;
    assign o_uart_tx   = r_tx;
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign w_push      = i_wr && (!o_full || w_pop);

    // Next-state, pop request and next line level for the frame sequencer.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            IDLE: begin
                if (!o_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) w_state_next = DATA;
            end
            DATA: begin
                w_tx_next = r_sh[0];
                if (w_baud_done && (r_bit_idx == 3'd7))
                    w_state_next = if_parity ? PARITY : STOP;
            end
            PARITY: begin
                w_tx_next = r_par;
                if (w_baud_done) w_state_next = STOP;
            end
            STOP: begin
                if (w_baud_done) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!o_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register and registered serial line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
        end
    end

    // Baud counter, bit index, shift register and parity of the frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_sh      <= '0;
            r_par     <= 1'b0;
        end else if (w_pop) begin
            r_sh      <= r_mem[r_rd_ptr];
            r_par     <= ^r_mem[r_rd_ptr];
            r_baud    <= '0;
            r_bit_idx <= '0;
        end else if (r_state != IDLE) begin
            if (w_baud_done) begin
                r_baud <= '0;
                if (r_state == DATA) begin
                    r_sh      <= r_sh >> 1;
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; a write into the slot being popped is safe since the pop reads the old value.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: tb/tb_txuart.sv
// tb/tb_txuart.sv - self-checking bench for txuart, 8N1 and 8E1 instances side by side
module tb_txuart;
    localparam int CPB   = 217;
    localparam int DEPTH = 4;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] wr   = 2'b00;
    logic [7:0] din [2];
    logic [1:0] tx, full, empty, busy;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: byte queue plus per-frame bit table indexed by elapsed clocks.
    logic [7:0]  mq [2][16];
    int          mhead [2];
    int          msize [2];
    int          mt [2];
    bit          mact [2];
    logic [10:0] mframe [2];
    logic        mline [2];
    logic [7:0]  rxq [$];

    always #20 clk = ~clk;

    txuart #(.CLK_FREQ(25000000), .baudRate(115200), .if_parity(1'b0), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rstn(rstn), .i_wr(wr[0]), .i_data(din[0]),
        .o_full(full[0]), .o_empty(empty[0]), .o_busy(busy[0]), .o_uart_tx(tx[0]));

    txuart #(.CLK_FREQ(25000000), .baudRate(115200), .if_parity(1'b1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_wr(wr[1]), .i_data(din[1]),
        .o_full(full[1]), .o_empty(empty[1]), .o_busy(busy[1]), .o_uart_tx(tx[1]));

    function automatic int frame_len(input int k);
        return (k == 1) ? 11 * CPB : 10 * CPB;
    endfunction

    task automatic model_reset(input int k);
        mhead[k] = 0; msize[k] = 0; mt[k] = 0; mact[k] = 1'b0;
        mframe[k] = '1; mline[k] = 1'b1;
    endtask

    task automatic model_step(input int k, input logic w, input logic [7:0] d);
        logic       nline;
        bit         pop, acc;
        logic [7:0] h;
        h     = 8'h00;
        nline = mact[k] ? mframe[k][mt[k] / CPB] : 1'b1;
        pop   = (msize[k] > 0) && (!mact[k] || (mt[k] == frame_len(k) - 1));
        acc   = w && ((msize[k] < DEPTH) || pop);
        if (pop) begin
            h = mq[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % 16;
            msize[k]--;
        end
        if (acc) begin
            mq[k][(mhead[k] + msize[k]) % 16] = d;
            msize[k]++;
        end
        if (pop) begin
            mact[k] = 1'b1; mt[k] = 0;
            mframe[k] = {1'b1, (k == 1) ? ^h : 1'b1, h, 1'b0};
        end else if (mact[k]) begin
            if (mt[k] == frame_len(k) - 1) mact[k] = 1'b0;
            else mt[k]++;
        end
        mline[k] = nline;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: advance the model on each rising edge, check outputs on the falling edge.
    initial begin
        logic [3:0] expv, actv;
        model_reset(0); model_reset(1);
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rstn) model_reset(k);
                else model_step(k, wr[k], din[k]);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                expv = {mline[k], msize[k] == DEPTH, msize[k] == 0, mact[k] || (msize[k] > 0)};
                actv = {tx[k], full[k], empty[k], busy[k]};
                vectors++;
                if (actv !== expv) begin
                    miscompares++;
                    $display("FAIL model inst%0d {tx,full,empty,busy}: got %b expected %b at %0t", k, actv, expv, $time);
                end
            end
        end
    end

    // Bench-side receiver on instance 0: samples bit centres after each start edge.
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (tx[0] === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                rb = 8'h00;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rb[b] = tx[0];
                end
                repeat (CPB) @(negedge clk);
                rxq.push_back(rb);
            end
        end
    end

    task automatic do_reset_check(input string tag);
        @(negedge clk);
        #3 rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            lit($sformatf("%s_tx%0d", tag, k), tx[k], 1);
            lit($sformatf("%s_full%0d", tag, k), full[k], 0);
            lit($sformatf("%s_empty%0d", tag, k), empty[k], 1);
            lit($sformatf("%s_busy%0d", tag, k), busy[k], 0);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_idle(input int k, input int limit, input string tag);
        int n;
        n = 0;
        while (busy[k] && n < limit) begin
            @(negedge clk);
            n++;
        end
        lit(tag, busy[k], 0);
    endtask

    initial begin
        int abits [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        logic [7:0] burst_exp [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h16};
        int nbad, idx;
        din[0] = 8'h00; din[1] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        for (int k = 0; k < 2; k++) begin
            lit($sformatf("rst_tx%0d", k), tx[k], 1);
            lit($sformatf("rst_full%0d", k), full[k], 0);
            lit($sformatf("rst_empty%0d", k), empty[k], 1);
            lit($sformatf("rst_busy%0d", k), busy[k], 0);
        end
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 0x41 on the 8N1 instance; 0x41 then 0x07 on the 8E1 instance
        wr = 2'b11; din[0] = 8'h41; din[1] = 8'h41;
        @(negedge clk); wr[0] = 1'b0; din[1] = 8'h07;
        lit("a_tx_high_n0", tx[0], 1);
        @(negedge clk); wr[1] = 1'b0;
        lit("a_tx_high_n1", tx[0], 1);
        for (int m = 2; m <= 4800; m++) begin
            @(negedge clk);
            if (m == 2) lit("a_tx_fall", tx[0], 0);
            for (int b = 0; b < 10; b++)
                if (m == 2 + b * CPB + CPB / 2) lit($sformatf("a_bit%0d", b), tx[0], abits[b]);
            if (m == 2170) lit("a_busy_last", busy[0], 1);
            if (m == 2171) lit("a_busy_drop", busy[0], 0);
            if (m == 2063) lit("b_par_41", tx[1], 0);
            if (m == 2280) lit("b_stop1", tx[1], 1);
            if (m == 2388) lit("b_stop1_end", tx[1], 1);
            if (m == 2389) lit("b_start2", tx[1], 0);
            if (m == 4450) lit("b_par_07", tx[1], 1);
            if (m == 4774) lit("b_busy_last", busy[1], 1);
            if (m == 4775) lit("b_busy_drop", busy[1], 0);
        end

        // Burst of six, then a write into a full FIFO on the STOP->START pop edge
        rxq.delete();
        wr[0] = 1'b1; din[0] = 8'h10;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            din[0] = 8'(8'h10 + i);
        end
        @(negedge clk); wr[0] = 1'b0;
        lit("burst_full", full[0], 1);
        repeat (2165) @(negedge clk);
        lit("full_before_pop", full[0], 1);
        wr[0] = 1'b1; din[0] = 8'h16;
        @(negedge clk); wr[0] = 1'b0;
        lit("full_after_pop_push", full[0], 1);
        wait_idle(0, 15000, "burst_idle");
        lit("burst_rx_count", rxq.size(), 6);
        for (int i = 0; i < 6 && i < rxq.size(); i++)
            lit($sformatf("burst_rx%0d", i), rxq[i], burst_exp[i]);

        // Random writes on both instances, including writes into a full FIFO
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                wr[k]  = ($urandom_range(0, 999) < 4);
                din[k] = 8'($urandom);
            end
        end
        @(negedge clk); wr = 2'b00;
        do_reset_check("rand_rst");
        repeat (3) @(negedge clk);

        // Reset midway through D3 with two bytes queued
        wr[0] = 1'b1; din[0] = 8'hA5;
        @(negedge clk); din[0] = 8'h3C;
        @(negedge clk); din[0] = 8'hFF;
        @(negedge clk); wr[0] = 1'b0;
        repeat (976) @(negedge clk);
        lit("d3_level", tx[0], 0);
        lit("d3_busy", busy[0], 1);
        lit("d3_queued_empty", empty[0], 0);
        do_reset_check("d3_rst");
        nbad = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) nbad++;
        end
        lit("quiet_after_rst", nbad, 0);

        // Pointer wrap: ten bytes, writing only while not full
        rxq.delete();
        idx = 0;
        for (int c = 0; c < 30000 && (idx < 10 || busy[0]); c++) begin
            @(negedge clk);
            if (idx < 10 && !full[0]) begin
                wr[0] = 1'b1; din[0] = 8'(idx); idx++;
            end else begin
                wr[0] = 1'b0;
            end
        end
        wr[0] = 1'b0;
        lit("wrap_all_written", idx, 10);
        wait_idle(0, 3000, "wrap_idle");
        lit("wrap_rx_count", rxq.size(), 10);
        for (int i = 0; i < 10 && i < rxq.size(); i++)
            lit($sformatf("wrap_rx%0d", i), rxq[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
